// File: rtl/lsu_mem_port.sv
// lsu_mem_port: CPU load/store port to a word memory with byte/halfword RMW stores.
// Optional LSU_ALIGN_CHECK_EN enables misaligned-access faults.
module lsu_mem_port (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic [10:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [2:0] OP_LB = 3'b000, OP_LH = 3'b001, OP_LW = 3'b010, OP_SB = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100, OP_LHU = 3'b101, OP_SH = 3'b110, OP_SW = 3'b111;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t state, state_n;

    logic [2:0]  op_q;
    logic [10:0] addr_q;
    logic [31:0] wdata_q, word_q, merged, ext, rep;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [3:0]  lane;
    logic        fault, fault_q, accept, is_store;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^addr[31:11];
    assign accept = (state == IDLE) && req;
    assign is_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

`ifdef LSU_ALIGN_CHECK_EN
    assign fault = (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && addr[0]) ||
                   (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00));
    assign misalign = done && fault_q;
`else
    assign fault = 1'b0;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q    <= op;
                addr_q  <= addr[10:0];
                wdata_q <= wdata;
                fault_q <= fault;
            end
            if (state == READ)
                word_q <= mem_rdata;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (req) state_n = fault ? RESP : (op == OP_SW) ? WRITE : READ;
            READ:  state_n = is_store ? WRITE : RESP;
            WRITE: state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    assign busy        = state != IDLE;
    assign done        = state == RESP;
    assign mem_read    = state == READ;
    assign mem_write   = state == WRITE;
    assign mem_address = {addr_q[10:2], 2'b00};

    // Store lanes: replicate the store data so any lane can pick it up directly.
    assign rep  = (op_q == OP_SB) ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
    assign lane = (op_q == OP_SB) ? (4'b0001 << addr_q[1:0]) : (addr_q[1] ? 4'b1100 : 4'b0011);

    always_comb begin
        merged = word_q;
        for (int i = 0; i < 4; i++)
            if (lane[i]) merged[8*i +: 8] = rep[8*i +: 8];
    end

    assign mem_wdata = (state == WRITE) ? ((op_q == OP_SW) ? wdata_q : merged) : '0;

    assign bsel = addr_q[1] ? (addr_q[0] ? word_q[31:24] : word_q[23:16])
                            : (addr_q[0] ? word_q[15:8] : word_q[7:0]);
    assign hsel = addr_q[1] ? word_q[31:16] : word_q[15:0];
    assign ext  = (op_q == OP_LB)  ? {{24{bsel[7]}}, bsel} :
                  (op_q == OP_LBU) ? {24'b0, bsel} :
                  (op_q == OP_LH)  ? {{16{hsel[15]}}, hsel} :
                  (op_q == OP_LHU) ? {16'b0, hsel} :
                  (op_q == OP_LW)  ? word_q : '0;
    assign rdata = (done && !fault_q) ? ext : '0;
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed scoreboard bench for lsu_mem_port with a falling-edge memory model.
module tb_lsu_mem_port;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, SB = 3'b011;
    localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, SH = 3'b110, SW = 3'b111;

    logic        clock = 1'b0, resetn = 1'b0, req = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] addr = '0, wdata = '0, rdata, mem_wdata, mem_rdata;
    logic        busy, done, misalign, mem_read, mem_write;
    logic [10:0] mem_address;
    logic [31:0] mem [0:511];

    int n_assert = 0, n_fail = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        logic        rd;
        logic        wr;
    } exp_t;
    exp_t sb_q[$];

    logic [10:0] last_waddr;
    logic [31:0] last_wdata;

    lsu_mem_port dut (
        .clock(clock), .resetn(resetn), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .misalign(misalign),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_address[10:2]];
    always @(negedge clock) if (mem_write) mem[mem_address[10:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [10:0] a,
                       input logic [31:0] w, input logic [31:0] er, input logic em,
                       input int el, input logic erd, input logic ewr, input bit hold);
        exp_t e;
        int lat;
        logic saw_rd, saw_wr;
        sb_q.push_back('{tag, er, em, el, erd, ewr});
        @(negedge clock);
        check({tag, "_idle"}, busy, 0);
        req = 1'b1; op = o; addr = {21'h0, a}; wdata = w;
        @(posedge clock);
        #1;
        if (hold) begin
            op = SW; addr = 32'h010; wdata = 32'hBAD0BAD0;
        end else req = 1'b0;
        lat = 0; saw_rd = 1'b0; saw_wr = 1'b0;
        while (1) begin
            @(negedge clock);
            lat++;
            if (mem_read) saw_rd = 1'b1;
            if (mem_write) begin
                saw_wr = 1'b1; last_waddr = mem_address; last_wdata = mem_wdata;
            end
            if (done || lat > 8) break;
        end
        req = 1'b0;
        e = sb_q.pop_front();
        check({e.tag, "_lat"}, lat, e.lat);
        check({e.tag, "_rdata"}, rdata, e.rdata);
        check({e.tag, "_mis"}, misalign, e.mis);
        check({e.tag, "_busy"}, busy, 1);
        check({e.tag, "_rd"}, saw_rd, e.rd);
        check({e.tag, "_wr"}, saw_wr, e.wr);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mis", misalign, 0);
        check("rst_mrd", mem_read, 0);
        check("rst_mwr", mem_write, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mwdata", mem_wdata, 0);
        check("rst_maddr", mem_address, 0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        run("sw", SW, 11'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        check("sw_waddr", last_waddr, 11'h010);
        check("sw_wdata", last_wdata, 32'hDEADBEEF);
        check("sw_mem4", mem[4], 32'hDEADBEEF);
        run("lb", LB, 11'h013, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        run("lbu", LBU, 11'h013, 32'h0, 32'h000000DE, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        run("sb", SB, 11'h011, 32'h00000055, 32'h0, 1'b0, 3, 1'b1, 1'b1, 1'b0);
        check("sb_mem4", mem[4], 32'hDEAD55EF);
`ifdef LSU_ALIGN_CHECK_EN
        run("lh_mis", LH, 11'h011, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        run("lw_mis", LW, 11'h013, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        run("sw_mis", SW, 11'h012, 32'h11111111, 32'h0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        check("sw_mis_mem4", mem[4], 32'hDEAD55EF);
`else
        run("lh_odd", LH, 11'h011, 32'h0, 32'h000055EF, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        run("lw_odd", LW, 11'h013, 32'h0, 32'hDEAD55EF, 1'b0, 2, 1'b1, 1'b0, 1'b0);
`endif
        run("lhu", LHU, 11'h012, 32'h0, 32'h0000DEAD, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        run("lh", LH, 11'h012, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        run("sh", SH, 11'h016, 32'h1234ABCD, 32'h0, 1'b0, 3, 1'b1, 1'b1, 1'b0);
        check("sh_mem5", mem[5], 32'hABCD0000);
        run("lw5", LW, 11'h014, 32'h0, 32'hABCD0000, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        run("lw_hold", LW, 11'h010, 32'h0, 32'hDEAD55EF, 1'b0, 2, 1'b1, 1'b0, 1'b1);
        check("hold_mem4", mem[4], 32'hDEAD55EF);

        @(negedge clock);
        req = 1'b1; op = SW; addr = 32'h018; wdata = 32'h12345678;
        @(posedge clock);
        #1;
        req = 1'b0;
        check("mid_mwr_pre", mem_write, 1);
        resetn = 1'b0;
        #1;
        check("mid_mwr", mem_write, 0);
        check("mid_busy", busy, 0);
        check("mid_maddr", mem_address, 0);
        check("mid_mwdata", mem_wdata, 0);
        @(negedge clock);
        #1;
        check("mid_mem6", mem[6], 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        run("lw6", LW, 11'h018, 32'h0, 32'h0, 1'b0, 2, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
